id_ex_pipe_stage: RTL
=====================

// Module: id_ex_pipe_stage
// PURPOSE
//  Parametrised elastic ID->EX pipeline stage. Carries one packed decode bundle per beat.
//  Uses a valid/ready handshake and a 2-entry (main + skid) buffer, so in_ready is a pure flop output.
//  Supports a flush (branch mispredict / exception) that kills everything in flight.
//  Sits between the decoder and issue/EX; sustains 1 beat/cycle with back-pressure.
// PARAMETERS
//  DATA_W        70  packed bundle width {opcode[6:0],funct3[2:0],funct7[6:0],rs1,rs2,rd[4:0],imm[31:0],lwSw[1:0],regWrite,memRead,memWrite,memToReg}
//  CLEAR_PAYLOAD 1   1: payload regs zeroed on reset/flush; 0: payload regs hold their old value (valid bits still cleared)
//  CNT_W         32  width of performance counters (ID_EX_PERF_CNT_EN only)
// PORTS
//  clk         in   1       clock; all logic rising-edge
//  rst         in   1       synchronous reset, active-high
//  flush       in   1       kill all buffered beats; takes effect at the next edge
//  in_valid    in   1       decode bundle valid
//  in_ready    out  1       stage can accept a beat (registered)
//  in_data     in   DATA_W  decode bundle
//  out_valid   out  1       EX-side bundle valid
//  out_ready   in   1       EX side accepts
//  out_data    out  DATA_W  bundle presented to EX (main register)
//  stall_cnt   out  CNT_W   cycles with out_valid & !out_ready (ID_EX_PERF_CNT_EN only)
//  bubble_cnt  out  CNT_W   cycles with !out_valid (ID_EX_PERF_CNT_EN only)
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  Reset values: state=EMPTY, in_ready=1, out_valid=0, out_data=0, skid=0, counters=0.
//  Handshake: in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
//   - A beat is held stable on out_data while out_valid&!out_ready.
//   - in_data is don't-care when in_valid=0.
//  FSM (state is the only control flop; in_ready=(state!=FULL), out_valid=(state!=EMPTY)):
//   EMPTY: in_fire -> main<=in_data, go BUSY.
//   BUSY:  in_fire & out_fire -> main<=in_data, stay BUSY
//          out_fire only       -> go EMPTY
//          in_fire only        -> skid<=in_data, go FULL
//          neither             -> hold
//   FULL:  in_ready=0; out_fire -> main<=skid, go BUSY; else hold.
//  Latency: in_fire at edge N gives out_valid=1 with that data after edge N (1 cycle), when EMPTY or draining.
//  Throughput: 1 beat/cycle sustained while out_ready=1.
//  Ordering: strict FIFO order; no beat is lost or duplicated except by flush/reset.
//  flush=1: next state EMPTY regardless of in_fire/out_fire in the same cycle.
//   - A beat offered in the flush cycle is dropped.
//   - An out_fire in the flush cycle still counts as consumed by EX.
//   - If CLEAR_PAYLOAD=1, main and skid are zeroed.
//  rst has priority over flush. Reset mid-stream behaves as flush, plus counters are cleared.
//  in_ready never depends combinationally on out_ready; there are no comb paths from in_* to out_*.
// CONFIGURATION
//  ID_EX_PERF_CNT_EN defined:
//   - stall_cnt / bubble_cnt ports exist.
//   - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
//   - Counters are cleared by rst only (not by flush).
//   - A flush cycle is counted by its pre-edge out_valid/out_ready.
//  ID_EX_PERF_CNT_EN undefined: counter ports and logic are absent; all other behaviour is identical.
// TESTING
//  1. rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_data=0; counters=0.
//  2. out_ready=1, send beats 0x01..0x10 back-to-back -> out_data 0x01..0x10 one cycle later, no gaps, in_ready stays 1.
//  3. Send A=0x0AA, B=0x0BB with out_ready=0 -> FULL, in_ready=0; C held off; out_ready=1 -> A, then B, then C, in order.
//  4. FULL (A,B), assert flush with in_valid=1 (D) -> next cycle out_valid=0, in_ready=1, data=0 (CLEAR_PAYLOAD=1); D never appears.
//  5. CLEAR_PAYLOAD=0, repeat 4 -> out_valid=0, out_data still 0x0AA.
//  6. ID_EX_PERF_CNT_EN, CNT_W=4, out_valid=1 & out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush leaves it 15; rst -> 0.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// =============================================================================
// Module      : id_ex_pipe_stage
// Description : Elastic ID->EX pipeline stage with main + skid buffer and flush.
//               Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module id_ex_pipe_stage #(
    parameter int DATA_W        = 70,
    parameter bit CLEAR_PAYLOAD = 1'b1
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int CNT_W         = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              w_in_fire;
    logic              w_out_fire;

    // Handshake outputs are pure decodes of the state flop: no in->out comb path.
    assign in_ready   = (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_q;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    main_d  = in_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    main_d = in_data;
                end else if (w_out_fire) begin
                    state_d = ST_EMPTY;
                end else if (w_in_fire) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush overrides everything; any beat offered this cycle is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_PAYLOAD) begin
                main_d = '0;
                skid_d = '0;
            end else begin
                main_d = main_q;
                skid_d = skid_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush does not clear them, only rst does.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
